// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared definitions for the alarm ring controller: UI mode code, FSM states,
// button bit positions and the packed time-of-day record.
package alarm_ring_ctrl_pkg;

    localparam logic [3:0] MODE_ALARM_SET = 4'b0000;

    localparam int BTN_SNOOZE_A = 0;
    localparam int BTN_SNOOZE_B = 1;
    localparam int BTN_STOP_A   = 2;
    localparam int BTN_STOP_B   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RING   = 2'd2,
        ST_SNOOZE = 2'd3
    } alarm_state_e;

    typedef struct packed {
        logic       meridiem;
        logic [6:0] hour;
        logic [6:0] min;
        logic [6:0] sec;
    } time_t;

    localparam int TIME_W = $bits(time_t);

    // All four fields must agree for the alarm to match.
    function automatic logic time_eq(input time_t a, input time_t b);
        return (a.meridiem == b.meridiem) && (a.hour == b.hour) &&
               (a.min == b.min) && (a.sec == b.sec);
    endfunction

endpackage

// File: rtl/alarm_time_match.sv
// Compares running time with the programmed alarm and flags the first cycle
// of a match, so a match held for several seconds fires only once.
module alarm_time_match
    import alarm_ring_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [TIME_W-1:0] cur_time,
    input  logic [TIME_W-1:0] alm_time,
    output logic              hit
);

    time_t cur_s;
    time_t alm_s;
    logic  match_s;
    logic  match_r;

    assign cur_s   = time_t'(cur_time);
    assign alm_s   = time_t'(alm_time);
    assign match_s = time_eq(cur_s, alm_s);

    // Remember last cycle's match for rising-edge detection.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            match_r <= 1'b0;
        end else begin
            match_r <= match_s;
        end
    end

    assign hit = match_s & ~match_r;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencing: arm/disarm, ring with 1 Hz buzzer pattern, snooze
// countdown with a per-event limit and automatic ring timeout.
module alarm_ring_ctrl
    import alarm_ring_ctrl_pkg::*;
#(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TICK_1HZ,
    input  logic [3:0] MODE,
    input  logic [3:0] NUM_SYNC,
    input  logic       ARM_BTN,
    input  logic       CUR_MERIDIEM,
    input  logic [6:0] CUR_HOUR,
    input  logic [6:0] CUR_MIN,
    input  logic [6:0] CUR_SEC,
    input  logic       ALM_MERIDIEM,
    input  logic [6:0] ALM_HOUR,
    input  logic [6:0] ALM_MIN,
    input  logic [6:0] ALM_SEC,
    output logic       ALARM_EN,
    output logic       RINGING,
    output logic       SNOOZING,
    output logic       BUZZ,
    output logic [8:0] SNOOZE_LEFT,
    output logic [1:0] SNOOZE_CNT
);

    localparam logic [7:0] RING_LAST  = 8'(RING_TIMEOUT_SEC - 1);
    localparam logic [8:0] SNOOZE_LEN = 9'(SNOOZE_SEC);
    localparam logic [1:0] SNOOZE_MAX = 2'(MAX_SNOOZE);

    logic [TIME_W-1:0] cur_time_s;
    logic [TIME_W-1:0] alm_time_s;
    logic              raw_hit_s;
    logic              hit_s;
    logic              stop_s;
    logic              snooze_s;

    alarm_state_e state_r;
    alarm_state_e state_nx_s;
    logic [7:0]   ring_cnt_r;
    logic [7:0]   ring_cnt_nx_s;
    logic         buzz_r;
    logic         buzz_nx_s;
    logic [8:0]   left_r;
    logic [8:0]   left_nx_s;
    logic [1:0]   snz_cnt_r;
    logic [1:0]   snz_cnt_nx_s;
    logic         alarm_en_r;
    logic         ringing_r;
    logic         snoozing_r;

    assign cur_time_s = {CUR_MERIDIEM, CUR_HOUR, CUR_MIN, CUR_SEC};
    assign alm_time_s = {ALM_MERIDIEM, ALM_HOUR, ALM_MIN, ALM_SEC};

    alarm_time_match u_match (
        .CLK      (CLK),
        .RESET    (RESET),
        .cur_time (cur_time_s),
        .alm_time (alm_time_s),
        .hit      (raw_hit_s)
    );

    // The edge detector still tracks matches in alarm-set mode, so leaving
    // that mode during a held match does not fire a late ring.
    assign hit_s    = raw_hit_s & (MODE != MODE_ALARM_SET);
    assign stop_s   = NUM_SYNC[BTN_STOP_A] | NUM_SYNC[BTN_STOP_B];
    assign snooze_s = NUM_SYNC[BTN_SNOOZE_A] | NUM_SYNC[BTN_SNOOZE_B];

    // Next-state and datapath decisions; a button in the same cycle as a tick
    // wins and the tick is dropped.
    always_comb begin
        state_nx_s    = state_r;
        ring_cnt_nx_s = ring_cnt_r;
        buzz_nx_s     = buzz_r;
        left_nx_s     = left_r;
        snz_cnt_nx_s  = snz_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (ARM_BTN) begin
                    state_nx_s = ST_ARMED;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (ARM_BTN) begin
                    state_nx_s = ST_IDLE;
                end else if (hit_s) begin
                    state_nx_s    = ST_RING;
                    ring_cnt_nx_s = 8'd0;
                    buzz_nx_s     = 1'b1;
                    snz_cnt_nx_s  = 2'd0;
                end else begin
                    state_nx_s = ST_ARMED;
                end
            end
            ST_RING: begin
                if (ARM_BTN) begin
                    state_nx_s    = ST_IDLE;
                    ring_cnt_nx_s = 8'd0;
                    buzz_nx_s     = 1'b0;
                    left_nx_s     = 9'd0;
                    snz_cnt_nx_s  = 2'd0;
                end else if (stop_s || (TICK_1HZ && (ring_cnt_r == RING_LAST))) begin
                    state_nx_s    = ST_ARMED;
                    ring_cnt_nx_s = 8'd0;
                    buzz_nx_s     = 1'b0;
                    left_nx_s     = 9'd0;
                    snz_cnt_nx_s  = 2'd0;
                end else if (snooze_s) begin
                    if (snz_cnt_r < SNOOZE_MAX) begin
                        state_nx_s   = ST_SNOOZE;
                        buzz_nx_s    = 1'b0;
                        left_nx_s    = SNOOZE_LEN;
                        snz_cnt_nx_s = snz_cnt_r + 2'd1;
                    end else begin
                        state_nx_s    = ST_ARMED;
                        ring_cnt_nx_s = 8'd0;
                        buzz_nx_s     = 1'b0;
                        left_nx_s     = 9'd0;
                        snz_cnt_nx_s  = 2'd0;
                    end
                end else if (TICK_1HZ) begin
                    buzz_nx_s = ~buzz_r;
                    if (ring_cnt_r != 8'hFF) begin
                        ring_cnt_nx_s = ring_cnt_r + 8'd1;
                    end else begin
                        ring_cnt_nx_s = ring_cnt_r;
                    end
                end else begin
                    state_nx_s = ST_RING;
                end
            end
            ST_SNOOZE: begin
                if (ARM_BTN) begin
                    state_nx_s    = ST_IDLE;
                    ring_cnt_nx_s = 8'd0;
                    buzz_nx_s     = 1'b0;
                    left_nx_s     = 9'd0;
                    snz_cnt_nx_s  = 2'd0;
                end else if (stop_s) begin
                    state_nx_s    = ST_ARMED;
                    ring_cnt_nx_s = 8'd0;
                    buzz_nx_s     = 1'b0;
                    left_nx_s     = 9'd0;
                    snz_cnt_nx_s  = 2'd0;
                end else if (TICK_1HZ) begin
                    if (left_r <= 9'd1) begin
                        state_nx_s    = ST_RING;
                        ring_cnt_nx_s = 8'd0;
                        buzz_nx_s     = 1'b1;
                        left_nx_s     = 9'd0;
                    end else begin
                        left_nx_s = left_r - 9'd1;
                    end
                end else begin
                    state_nx_s = ST_SNOOZE;
                end
            end
            default: begin
                state_nx_s    = ST_IDLE;
                ring_cnt_nx_s = 8'd0;
                buzz_nx_s     = 1'b0;
                left_nx_s     = 9'd0;
                snz_cnt_nx_s  = 2'd0;
            end
        endcase
    end

    // State, counters and registered status flags; reset clears BUZZ at once.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r    <= ST_IDLE;
            ring_cnt_r <= 8'd0;
            buzz_r     <= 1'b0;
            left_r     <= 9'd0;
            snz_cnt_r  <= 2'd0;
            alarm_en_r <= 1'b0;
            ringing_r  <= 1'b0;
            snoozing_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            ring_cnt_r <= ring_cnt_nx_s;
            buzz_r     <= buzz_nx_s;
            left_r     <= left_nx_s;
            snz_cnt_r  <= snz_cnt_nx_s;
            alarm_en_r <= (state_nx_s != ST_IDLE);
            ringing_r  <= (state_nx_s == ST_RING);
            snoozing_r <= (state_nx_s == ST_SNOOZE);
        end
    end

    assign ALARM_EN    = alarm_en_r;
    assign RINGING     = ringing_r;
    assign SNOOZING    = snoozing_r;
    assign BUZZ        = buzz_r;
    assign SNOOZE_LEFT = left_r;
    assign SNOOZE_CNT  = snz_cnt_r;

endmodule
